key_frame_queue: RTL and testbench

Keyboard event buffer sitting directly upstream of the square motion block. It samples the raw USB keycode on the system clock and queues every new non-zero key press in a small FIFO. It presents exactly one keycode per frame, held stable between frame ticks. Short taps that start and end within one frame are therefore not lost before the frame-rate motion logic sees them.

---
 rtl/key_frame_queue_if.sv | 35 +++
 rtl/key_frame_queue.sv | 117 +++++++++++
 tb/tb_key_frame_queue.sv | 134 +++++++++++++
 3 files changed

// File: rtl/key_frame_queue_if.sv
// Keyboard frame-queue bus: raw keycode and frame strobe in, per-frame
// keycode, source flag, occupancy and sticky overflow out.
interface key_frame_queue_if #(
  parameter int DEPTH = 4,
  parameter int KEY_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [KEY_W-1:0] keycode_in;
  logic             frame_tick;
  logic [KEY_W-1:0] keycode_out;
  logic             from_queue;
  logic [CW-1:0]    count;
  logic             overflow;

  // Producer of keycodes and frame ticks, consumer of the per-frame key.
  modport master (
    output keycode_in,
    output frame_tick,
    input  keycode_out,
    input  from_queue,
    input  count,
    input  overflow
  );

  // The queue itself.
  modport slave (
    input  keycode_in,
    input  frame_tick,
    output keycode_out,
    output from_queue,
    output count,
    output overflow
  );
endinterface

// File: rtl/key_frame_queue.sv
// Keyboard event buffer: queues each new non-zero key press and presents
// one keycode per video frame, held stable between frame ticks, so taps
// shorter than a frame still reach the frame-rate motion logic.
module key_frame_queue #(
  parameter int DEPTH = 4,
  parameter int KEY_W = 8
) (
  input logic              Clk,
  input logic              Reset,
  key_frame_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [KEY_W-1:0] mem_r [DEPTH];
  logic [KEY_W-1:0] prev_key_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [KEY_W-1:0] key_out_r;
  logic             from_queue_r;
  logic             overflow_r;

  logic             push_s;
  logic             pop_s;
  logic             bypass_s;
  logic             wr_s;
  logic             drop_s;
  logic [CW-1:0]    count_nxt_s;
  logic [KEY_W-1:0] key_out_nxt_s;
  logic             from_queue_nxt_s;

  // Event classification: a press is any change to a non-zero code; a tick
  // on an empty queue hands a simultaneous press straight to the output.
  always_comb begin
    push_s   = (bus.keycode_in != prev_key_r) && (bus.keycode_in != {KEY_W{1'b0}});
    pop_s    = bus.frame_tick && (count_r != {CW{1'b0}});
    bypass_s = bus.frame_tick && push_s && (count_r == {CW{1'b0}});
    // A same-cycle pop frees a slot, so a full queue still accepts the press.
    wr_s     = push_s && !bypass_s && ((count_r < DEPTH_C) || pop_s);
    drop_s   = push_s && !bypass_s && !((count_r < DEPTH_C) || pop_s);
  end

  // Next occupancy and next per-frame output.
  always_comb begin
    count_nxt_s      = count_r;
    key_out_nxt_s    = key_out_r;
    from_queue_nxt_s = from_queue_r;

    if (wr_s && !pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (pop_s && !wr_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end

    if (bus.frame_tick) begin
      if (bypass_s) begin
        key_out_nxt_s    = bus.keycode_in;
        from_queue_nxt_s = 1'b1;
      end else if (pop_s) begin
        key_out_nxt_s    = mem_r[rd_ptr_r];
        from_queue_nxt_s = 1'b1;
      end else begin
        // Nothing queued: present whatever key is currently held.
        key_out_nxt_s    = bus.keycode_in;
        from_queue_nxt_s = 1'b0;
      end
    end else begin
      key_out_nxt_s    = key_out_r;
      from_queue_nxt_s = from_queue_r;
    end
  end

  // Control state: edge detector, pointers, occupancy, outputs, sticky overflow.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prev_key_r   <= {KEY_W{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      key_out_r    <= {KEY_W{1'b0}};
      from_queue_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      prev_key_r   <= bus.keycode_in;
      count_r      <= count_nxt_s;
      key_out_r    <= key_out_nxt_s;
      from_queue_r <= from_queue_nxt_s;
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Queue storage; stale contents are harmless because the pointers and
  // occupancy are cleared on reset.
  always_ff @(posedge Clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= bus.keycode_in;
    end
  end

  assign bus.keycode_out = key_out_r;
  assign bus.from_queue  = from_queue_r;
  assign bus.count       = count_r;
  assign bus.overflow    = overflow_r;

endmodule

// File: tb/tb_key_frame_queue.sv
// Directed self-checking bench for key_frame_queue (DEPTH=4, KEY_W=8).
module tb_key_frame_queue;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  key_frame_queue_if #(.DEPTH(4), .KEY_W(8)) bus ();

  key_frame_queue #(.DEPTH(4), .KEY_W(8)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clock cycle; returns at the following falling edge.
  task automatic drive(input logic [7:0] k, input logic t);
    bus.keycode_in = k;
    bus.frame_tick = t;
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [7:0] key, input logic fq, input logic [2:0] cnt);
    check({tag, "_key"}, {24'd0, bus.keycode_out}, {24'd0, key});
    check({tag, "_fq"},  {31'd0, bus.from_queue},  {31'd0, fq});
    check({tag, "_cnt"}, {29'd0, bus.count},       {29'd0, cnt});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.keycode_in = 8'h1A;
    bus.frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset with 1A held
    check_out("rst", 8'h00, 1'b0, 3'd0);
    check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    rst = 1'b0;
    drive(8'h1A, 1'b0);
    check("rel_push_cnt", {29'd0, bus.count}, 32'd1);
    drive(8'h1A, 1'b1);
    check_out("rel_tick", 8'h1A, 1'b1, 3'd0);

    // Tap 04 for three cycles, then release, all inside one frame
    drive(8'h04, 1'b0);
    check_out("mid_frame_stable", 8'h1A, 1'b1, 3'd1);
    drive(8'h04, 1'b0);
    drive(8'h04, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    check("tap_one_event", {29'd0, bus.count}, 32'd1);
    drive(8'h00, 1'b1);
    check_out("tap_tick", 8'h04, 1'b1, 3'd0);
    drive(8'h00, 1'b1);
    check_out("tap_held", 8'h00, 1'b0, 3'd0);

    // Five presses into a four-entry queue
    drive(8'h1A, 1'b0); drive(8'h00, 1'b0);
    drive(8'h04, 1'b0); drive(8'h00, 1'b0);
    drive(8'h16, 1'b0); drive(8'h00, 1'b0);
    drive(8'h07, 1'b0); drive(8'h00, 1'b0);
    check("full_cnt", {29'd0, bus.count}, 32'd4);
    check("full_no_ovf", {31'd0, bus.overflow}, 32'd0);
    drive(8'h1A, 1'b0);
    check("drop_cnt", {29'd0, bus.count}, 32'd4);
    check("drop_ovf", {31'd0, bus.overflow}, 32'd1);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b1); check_out("drain0", 8'h1A, 1'b1, 3'd3);
    drive(8'h00, 1'b1); check_out("drain1", 8'h04, 1'b1, 3'd2);
    drive(8'h00, 1'b1); check_out("drain2", 8'h16, 1'b1, 3'd1);
    drive(8'h00, 1'b1); check_out("drain3", 8'h07, 1'b1, 3'd0);
    drive(8'h00, 1'b1); check_out("drain_held", 8'h00, 1'b0, 3'd0);
    check("ovf_sticky", {31'd0, bus.overflow}, 32'd1);

    // Mid-frame asynchronous reset with three entries queued
    drive(8'h04, 1'b0); drive(8'h00, 1'b0);
    drive(8'h16, 1'b0); drive(8'h00, 1'b0);
    drive(8'h07, 1'b0); drive(8'h00, 1'b0);
    drive(8'h1A, 1'b0); drive(8'h00, 1'b0);
    drive(8'h00, 1'b1);
    check_out("pre_rst", 8'h04, 1'b1, 3'd3);
    bus.frame_tick = 1'b0;
    rst = 1'b1;
    #1;
    check_out("async_rst", 8'h00, 1'b0, 3'd0);
    check("async_rst_ovf", {31'd0, bus.overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(8'h00, 1'b1);
    check_out("post_rst_tick", 8'h00, 1'b0, 3'd0);

    // Full queue, new press 04 coincident with a tick
    drive(8'h1A, 1'b0); drive(8'h00, 1'b0);
    drive(8'h04, 1'b0); drive(8'h00, 1'b0);
    drive(8'h16, 1'b0); drive(8'h00, 1'b0);
    drive(8'h07, 1'b0); drive(8'h00, 1'b0);
    check("refill_cnt", {29'd0, bus.count}, 32'd4);
    drive(8'h04, 1'b1);
    check_out("full_tick_push", 8'h1A, 1'b1, 3'd4);
    check("full_tick_ovf", {31'd0, bus.overflow}, 32'd0);
    drive(8'h00, 1'b1); check_out("rd1", 8'h04, 1'b1, 3'd3);
    drive(8'h00, 1'b1); check_out("rd2", 8'h16, 1'b1, 3'd2);
    drive(8'h00, 1'b1); check_out("rd3", 8'h07, 1'b1, 3'd1);
    drive(8'h00, 1'b1); check_out("rd4_wrapped", 8'h04, 1'b1, 3'd0);
    drive(8'h00, 1'b1); check_out("rd_held", 8'h00, 1'b0, 3'd0);

    // Empty queue, press 16 coincident with a tick: bypass
    drive(8'h16, 1'b1);
    check_out("bypass", 8'h16, 1'b1, 3'd0);
    drive(8'h16, 1'b0);
    check_out("bypass_hold", 8'h16, 1'b1, 3'd0);
    drive(8'h16, 1'b1);
    check_out("bypass_held_tick", 8'h16, 1'b0, 3'd0);
    check("final_ovf", {31'd0, bus.overflow}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
